// File: rtl/accel_spi_responder.sv
`timescale 1ns/1ps
// Mode-3 SPI slave emulating the accelerometer register-read interface (64 x 8 register file).
// Define SPI_DRDY_INT_EN to enable the data-ready interrupt on int1; otherwise int1 is tied low.
module accel_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_csn,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy,
    output logic        int1
);

    typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, sdi_sync;
    logic                   sck_d, csn_d;
    logic                   sck_s, csn_s, sdi_s;
    logic                   start_evt, stop_evt, sck_rise, sck_fall;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             shift_out;
    logic [7:0]             rx_byte, rd_data;
    logic [5:0]             addr, next_addr, ld_addr;
    logic                   mb, byte_done, addr_is_snap, wr_blocked;
    logic [7:0]             regfile [64];
    logic [15:0]            live_x, live_y, live_z;
    logic [15:0]            shadow_x, shadow_y, shadow_z;

    // Synchronizers reset to the bus idle levels so reset release creates no spurious edges.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '1;
            csn_sync <= '1;
            sdi_sync <= '0;
            sck_d    <= 1'b1;
            csn_d    <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            csn_d    <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign start_evt = csn_d & ~csn_s;
    assign stop_evt  = ~csn_d & csn_s;
    assign sck_rise  = ~sck_d & sck_s & ~csn_s;
    assign sck_fall  = sck_d & ~sck_s & ~csn_s;

    assign rx_byte      = {shift_in, sdi_s};
    assign byte_done    = sck_rise && (bit_cnt == 3'd7);
    assign addr_is_snap = (addr >= 6'h32) && (addr <= 6'h37);
    assign wr_blocked   = (addr == 6'h00) || addr_is_snap;
    assign next_addr    = mb ? addr + 6'd1 : addr;
    assign ld_addr      = (state == CMD) ? rx_byte[5:0] : next_addr;

    // Byte to present next: the commanded address on entry to RD, the following one afterwards.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_data = regfile[ld_addr];
        case (ld_addr)
            6'h00:   rd_data = DEVID;
            6'h32:   rd_data = shadow_x[7:0];
            6'h33:   rd_data = shadow_x[15:8];
            6'h34:   rd_data = shadow_y[7:0];
            6'h35:   rd_data = shadow_y[15:8];
            6'h36:   rd_data = shadow_z[7:0];
            6'h37:   rd_data = shadow_z[15:8];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_evt) state_next = CMD;
            CMD:     if (byte_done) state_next = rx_byte[7] ? RD : WR;
            default: ;
        endcase
        if (stop_evt) state_next = IDLE;
    end

    // NOTE: the register file is reset along with everything else, so it stays in flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt       <= '0;
            shift_in      <= '0;
            shift_out     <= '0;
            addr          <= '0;
            mb            <= 1'b0;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            live_x        <= '0;
            live_y        <= '0;
            live_z        <= '0;
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_z      <= '0;
            for (int i = 0; i < 64; i++) regfile[i] <= '0;
        end else begin
            reg_wr_strobe <= 1'b0;
            if (sample_valid) begin
                live_x <= sample_x;
                live_y <= sample_y;
                live_z <= sample_z;
            end
            if (start_evt) begin
                shadow_x <= live_x;
                shadow_y <= live_y;
                shadow_z <= live_z;
                bit_cnt  <= '0;
            end
            if (stop_evt) begin
                bit_cnt <= '0;
            end else begin
                case (state)
                    CMD: if (sck_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mb   <= rx_byte[6];
                            addr <= rx_byte[5:0];
                            if (rx_byte[7]) shift_out <= rd_data;
                        end
                    end
                    // Bit7 of each byte is already on SDO when the byte starts, so its first fall holds.
                    RD: if (sck_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr      <= next_addr;
                            shift_out <= rd_data;
                        end
                    end else if (sck_fall && bit_cnt != 3'd0) begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                    WR: if (sck_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr <= next_addr;
                            if (!wr_blocked) begin
                                regfile[addr] <= rx_byte;
                                reg_wr_strobe <= 1'b1;
                                reg_wr_addr   <= addr;
                                reg_wr_data   <= rx_byte;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy       = (state != IDLE);
    assign spi_sdo_oe = (state == RD);
    assign spi_sdo    = (state == RD) & shift_out[7];

`ifdef SPI_DRDY_INT_EN
    logic drdy_flag;

    // Set wins over a coincident clear; bit7 of 0x2E only masks the pin, not the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       drdy_flag <= 1'b0;
        else if (sample_valid)                           drdy_flag <= 1'b1;
        else if (state == RD && byte_done && addr_is_snap) drdy_flag <= 1'b0;
    end

    assign int1 = drdy_flag & regfile[6'h2E][7];
`else
    assign int1 = 1'b0;
`endif

endmodule

// File: tb/tb_accel_spi_responder.sv
`timescale 1ns/1ps
// Self-checking bench for accel_spi_responder: table of SPI transactions plus hand-written corner cases.
module tb_accel_spi_responder;

    localparam int HALF = 240;   // SPI half period (~2 MHz against a 25 MHz system clock)

`ifdef SPI_DRDY_INT_EN
    localparam logic DRDY = 1'b1;
`else
    localparam logic DRDY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic        sample_valid = 1'b0;
    logic        reg_wr_strobe;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy, int1;

    int n_checks = 0;
    int n_fail   = 0;
    logic        int1_seen = 1'b0;
    logic [7:0]  rd_exp_q [$];
    logic [13:0] wr_exp_q [$];

    typedef struct {
        logic [7:0]      cmd;
        int              n;
        logic [0:5][7:0] d;      // read: expected bytes, write: data sent
        logic            ld;     // pulse sample_valid with smp before the transaction
        logic [47:0]     smp;    // {x, y, z}
    } txn_t;

    txn_t tbl [11];

    accel_spi_responder dut (
        .clk(clk), .reset(reset),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .sample_valid(sample_valid),
        .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .busy(busy), .int1(int1)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (reg_wr_strobe === 1'b1) begin
            if (wr_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr_strobe: got addr %0h data %0h, expected no strobe",
                         reg_wr_addr, reg_wr_data);
            end else begin
                check("wr_strobe_addr_data", {18'd0, reg_wr_addr, reg_wr_data}, {18'd0, wr_exp_q.pop_front()});
            end
        end
        if (int1 !== 1'b0) int1_seen = 1'b1;
    end

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        #40;
        sample_valid = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input logic exp_oe, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_clk = 1'b0;
            spi_sdi = tx[i];
            #HALF;
            spi_clk = 1'b1;
            rx[i]   = spi_sdo;
            if (i == 7) check("sdo_oe_in_byte", {31'd0, spi_sdo_oe}, {31'd0, exp_oe});
            #HALF;
        end
    endtask

    task automatic read_and_score(output logic [7:0] rx);
        xfer_byte(8'h00, 1'b1, rx);
        if (rd_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_scoreboard_empty: got %0h, expected nothing queued", rx);
        end else begin
            check("rd_byte", {24'd0, rx}, {24'd0, rd_exp_q.pop_front()});
        end
    endtask

    task automatic cs_begin();
        spi_csn = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        spi_csn = 1'b1;
        #HALF;
        check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
        check("oe_after_cs_rise", {31'd0, spi_sdo_oe}, 32'd0);
        check("wr_queue_drained", wr_exp_q.size(), 32'd0);
        #HALF;
    endtask

    task automatic run_txn(input txn_t t);
        logic [7:0] rx;
        logic [5:0] a;
        if (t.ld) pulse_sample(t.smp[47:32], t.smp[31:16], t.smp[15:0]);
        cs_begin();
        xfer_byte(t.cmd, 1'b0, rx);
        for (int j = 0; j < t.n; j++) begin
            if (t.cmd[7]) begin
                rd_exp_q.push_back(t.d[j]);
                read_and_score(rx);
            end else begin
                a = t.cmd[5:0];
                if (t.cmd[6]) a = a + 6'(j);
                if (a != 6'h00 && !(a >= 6'h32 && a <= 6'h37)) wr_exp_q.push_back({a, t.d[j]});
                xfer_byte(t.d[j], 1'b0, rx);
            end
        end
        cs_end();
    endtask

    task automatic abort_write();
        logic [7:0] rx;
        logic [7:0] partial;
        partial = 8'hC3;
        cs_begin();
        xfer_byte(8'h7F, 1'b0, rx);
        for (int i = 7; i >= 3; i--) begin
            spi_clk = 1'b0;
            spi_sdi = partial[i];
            #HALF;
            spi_clk = 1'b1;
            #HALF;
        end
        cs_end();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        logic [7:0] rx;

        tbl[0]  = '{cmd: 8'h80, n: 1, d: {8'hE5, 40'h0},                             ld: 1'b0, smp: 48'h0};
        tbl[1]  = '{cmd: 8'hF2, n: 6, d: {8'h34, 8'h12, 8'hF0, 8'hFF, 8'h01, 8'h00}, ld: 1'b1, smp: 48'h1234_FFF0_0001};
        tbl[2]  = '{cmd: 8'h6D, n: 2, d: {8'h08, 8'h0B, 32'h0},                      ld: 1'b0, smp: 48'h0};
        tbl[3]  = '{cmd: 8'hED, n: 2, d: {8'h08, 8'h0B, 32'h0},                      ld: 1'b0, smp: 48'h0};
        tbl[4]  = '{cmd: 8'h72, n: 1, d: {8'h55, 40'h0},                             ld: 1'b0, smp: 48'h0};
        tbl[5]  = '{cmd: 8'hB2, n: 2, d: {8'h34, 8'h34, 32'h0},                      ld: 1'b0, smp: 48'h0};
        tbl[6]  = '{cmd: 8'h40, n: 1, d: {8'h11, 40'h0},                             ld: 1'b0, smp: 48'h0};
        tbl[7]  = '{cmd: 8'h05, n: 2, d: {8'h01, 8'h02, 32'h0},                      ld: 1'b0, smp: 48'h0};
        tbl[8]  = '{cmd: 8'h85, n: 2, d: {8'h02, 8'h02, 32'h0},                      ld: 1'b0, smp: 48'h0};
        tbl[9]  = '{cmd: 8'h7F, n: 1, d: {8'h5A, 40'h0},                             ld: 1'b0, smp: 48'h0};
        tbl[10] = '{cmd: 8'hFF, n: 2, d: {8'h5A, 8'hE5, 32'h0},                      ld: 1'b0, smp: 48'h0};

        // Reset state (inputs change 7 ns after a clock edge throughout).
        #107;
        check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
        check("rst_sdo_oe", {31'd0, spi_sdo_oe}, 32'd0);
        check("rst_strobe", {31'd0, reg_wr_strobe}, 32'd0);
        check("rst_wr_addr_data", {18'd0, reg_wr_addr, reg_wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_int1", {31'd0, int1}, 32'd0);
        reset = 1'b0;
        #200;
        check("busy_after_release", {31'd0, busy}, 32'd0);

        // SPI clock activity with chip select high must be ignored.
        for (int i = 0; i < 16; i++) begin
            spi_clk = ~spi_clk;
            spi_sdi = ~spi_sdi;
            #HALF;
        end
        spi_clk = 1'b1;
        #HALF;
        check("busy_sck_while_cs_high", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (i == 10) begin
                abort_write();
                check("abort_idle_busy", {31'd0, busy}, 32'd0);
            end
            run_txn(tbl[i]);
        end

        // Coherency: a mid-burst sample update must not disturb the snapshot.
        cs_begin();
        xfer_byte(8'hF2, 1'b0, rx);
        rd_exp_q.push_back(8'h34);
        read_and_score(rx);
        pulse_sample(16'hAAAA, 16'hFFF0, 16'h0001);
        foreach (tbl[1].d[j]) if (j > 0) rd_exp_q.push_back(tbl[1].d[j]);
        for (int j = 1; j < 6; j++) read_and_score(rx);
        cs_end();
        t = '{cmd: 8'hF2, n: 2, d: {8'hAA, 8'hAA, 32'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);

        // Data-ready interrupt (expected low throughout when the feature is not built).
        t = '{cmd: 8'h2E, n: 1, d: {8'h80, 40'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);
        check("int1_before_sample", {31'd0, int1}, 32'd0);
        pulse_sample(16'hAAAA, 16'hFFF0, 16'h0001);
        check("int1_after_sample", {31'd0, int1}, {31'd0, DRDY});
        cs_begin();
        xfer_byte(8'hF2, 1'b0, rx);
        check("int1_during_cmd", {31'd0, int1}, {31'd0, DRDY});
        rd_exp_q.push_back(8'hAA);
        read_and_score(rx);
        check("int1_cleared_after_byte", {31'd0, int1}, 32'd0);
        cs_end();
        t = '{cmd: 8'h2E, n: 1, d: {8'h00, 40'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);
        pulse_sample(16'hAAAA, 16'hFFF0, 16'h0001);
        check("int1_masked", {31'd0, int1}, 32'd0);
        t = '{cmd: 8'h2E, n: 1, d: {8'h80, 40'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);
        check("int1_unmasked_flag_kept", {31'd0, int1}, {31'd0, DRDY});

        // Reset in the middle of a read forces the reset state at once.
        cs_begin();
        xfer_byte(8'h80, 1'b0, rx);
        spi_clk = 1'b0;
        #HALF;
        spi_clk = 1'b1;
        check("oe_mid_read", {31'd0, spi_sdo_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_oe", {31'd0, spi_sdo_oe}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_int1", {31'd0, int1}, 32'd0);
        spi_csn = 1'b1;
        #(HALF - 1);
        reset = 1'b0;
        #HALF;
        check("rst_mid_wr_regs", {18'd0, reg_wr_addr, reg_wr_data}, 32'd0);
        t = '{cmd: 8'hAD, n: 1, d: {8'h00, 40'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);
        t = '{cmd: 8'hB6, n: 1, d: {8'h00, 40'h0}, ld: 1'b0, smp: 48'h0};
        run_txn(t);

`ifndef SPI_DRDY_INT_EN
        check("int1_never_high", {31'd0, int1_seen}, 32'd0);
`endif
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
